// File: rtl/reg8_serializer.sv
// Parallel-to-serial transmitter: captures one word on load, shifts it out one bit per enabled clock.
// Optional even-parity trailer bit and parity_bit port when PARITY_EN is defined.
module reg8_serializer #(
    parameter int WIDTH     = 8,    // 2..32
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
`ifdef PARITY_EN
    output logic             parity_bit,
`endif
    output logic             done
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
`ifdef PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
`ifdef PARITY_EN
    logic             par_q,   par_d;
`endif

    logic             cur_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // The output end of the shift register depends on bit order; vacated bits fill with 0.
    assign cur_bit       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    assign ready = (state_q == ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
`ifdef PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
`ifdef PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
`ifdef PARITY_EN
        par_d      = par_q;
        parity_bit = 1'b0;
`endif
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // en is deliberately ignored here; only load starts a frame.
                if (load) begin
                    shreg_d = d;
                    cnt_d   = CNT_LAST;
`ifdef PARITY_EN
                    par_d   = ^d;
`endif
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                sout       = cur_bit;
                sout_valid = 1'b1;
                if (en) begin
                    if (cnt_q != '0) begin
                        shreg_d = shreg_shifted;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else begin
`ifdef PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end

`ifdef PARITY_EN
            ST_PARITY: begin
                sout       = par_q;
                sout_valid = 1'b1;
                parity_bit = 1'b1;
                if (en) begin
                    state_d = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg8_serializer.sv
// Directed bench: drives an MSB-first and an LSB-first instance with the same inputs and
// checks both serial streams against hand-computed bit sequences from a vector table.
module tb_reg8_serializer;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic       load;
    logic       en;

    logic ready_m, sout_m, valid_m, done_m;
    logic ready_l, sout_l, valid_l, done_l;
`ifdef PARITY_EN
    logic pbit_m, pbit_l;
`endif

    int n_vec;
    int n_err;

    reg8_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load       (load),
        .en         (en),
        .ready      (ready_m),
        .sout       (sout_m),
        .sout_valid (valid_m),
`ifdef PARITY_EN
        .parity_bit (pbit_m),
`endif
        .done       (done_m)
    );

    reg8_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .load       (load),
        .en         (en),
        .ready      (ready_l),
        .sout       (sout_l),
        .sout_valid (valid_l),
`ifdef PARITY_EN
        .parity_bit (pbit_l),
`endif
        .done       (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Checks idle/reset-like outputs on both instances.
    task automatic check_quiet(input string tag, input logic exp_ready);
        check({tag, " ready_m"}, ready_m, exp_ready);
        check({tag, " ready_l"}, ready_l, exp_ready);
        check({tag, " valid_m"}, valid_m, 1'b0);
        check({tag, " valid_l"}, valid_l, 1'b0);
        check({tag, " sout_m"},  sout_m,  1'b0);
        check({tag, " sout_l"},  sout_l,  1'b0);
        check({tag, " done_m"},  done_m,  1'b0);
        check({tag, " done_l"},  done_l,  1'b0);
`ifdef PARITY_EN
        check({tag, " pbit_m"},  pbit_m,  1'b0);
        check({tag, " pbit_l"},  pbit_l,  1'b0);
`endif
    endtask

    task automatic check_bit(input string tag, input logic exp_m, input logic exp_l);
        check({tag, " sout_m"},  sout_m,  exp_m);
        check({tag, " sout_l"},  sout_l,  exp_l);
        check({tag, " valid_m"}, valid_m, 1'b1);
        check({tag, " valid_l"}, valid_l, 1'b1);
        check({tag, " ready_m"}, ready_m, 1'b0);
        check({tag, " done_m"},  done_m,  1'b0);
        check({tag, " done_l"},  done_l,  1'b0);
`ifdef PARITY_EN
        check({tag, " pbit_m"},  pbit_m,  1'b0);
`endif
    endtask

    typedef struct {
        logic [7:0] d;
        logic [7:0] exp_msb;   // transmitted order: bit 7 first .. bit 0 last
        logic [7:0] exp_lsb;
        logic       exp_par;
        int         stall_at;  // bit index to stall after, -1 = none
        int         stall_len;
        bit         scramble;  // change d and pulse load mid-frame
        int         abort_at;  // bit index during which reset hits, -1 = none
    } vec_t;

    // All inputs change and all outputs are sampled on the falling edge.
    task automatic run_frame(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        d    = v.d;
        load = 1'b1;
        en   = 1'b1;
        check({tag, " ready_m pre"}, ready_m, 1'b1);
        check({tag, " ready_l pre"}, ready_l, 1'b1);
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_bit($sformatf("%s bit%0d", tag, i), v.exp_msb[7-i], v.exp_lsb[7-i]);
            if (v.scramble && i == 2) begin
                d    = 8'h00;
                load = 1'b1;
            end
            if (v.scramble && i == 5) begin
                load = 1'b0;
            end
            if (i == v.abort_at) begin
                #2 rst = 1'b0;
                #1 check_quiet({tag, " abort"}, 1'b1);
                @(negedge clk);
                check_quiet({tag, " abort hold"}, 1'b1);
                rst = 1'b1;
                @(negedge clk);
                check_quiet({tag, " abort idle"}, 1'b1);
                return;
            end
            if (i == v.stall_at) begin
                en = 1'b0;
                for (int s = 0; s < v.stall_len; s++) begin
                    @(negedge clk);
                    check_bit($sformatf("%s stall%0d", tag, s), v.exp_msb[7-i], v.exp_lsb[7-i]);
                end
                en = 1'b1;
            end
            @(negedge clk);
        end
`ifdef PARITY_EN
        check({tag, " par sout_m"}, sout_m, v.exp_par);
        check({tag, " par sout_l"}, sout_l, v.exp_par);
        check({tag, " par pbit_m"}, pbit_m, 1'b1);
        check({tag, " par pbit_l"}, pbit_l, 1'b1);
        check({tag, " par valid_m"}, valid_m, 1'b1);
        @(negedge clk);
`endif
        check({tag, " done_m"},  done_m,  1'b1);
        check({tag, " done_l"},  done_l,  1'b1);
        check({tag, " dvalid_m"}, valid_m, 1'b0);
        check({tag, " dready_m"}, ready_m, 1'b0);
        check({tag, " dready_l"}, ready_l, 1'b0);
        @(negedge clk);
        check_quiet({tag, " post"}, 1'b1);
    endtask

    vec_t vecs[8];

    initial begin
        n_vec = 0;
        n_err = 0;

        vecs[0] = '{8'hAB, 8'hAB, 8'hD5, 1'b1, -1, 0, 1'b0, -1};
        vecs[1] = '{8'hAB, 8'hAB, 8'hD5, 1'b1, -1, 0, 1'b1, -1};
        vecs[2] = '{8'hAB, 8'hAB, 8'hD5, 1'b1,  2, 3, 1'b0, -1};
        vecs[3] = '{8'hAB, 8'hAB, 8'hD5, 1'b1, -1, 0, 1'b0,  4};
        vecs[4] = '{8'h5A, 8'h5A, 8'h5A, 1'b0, -1, 0, 1'b0, -1};
        vecs[5] = '{8'h03, 8'h03, 8'hC0, 1'b0, -1, 0, 1'b0, -1};
        vecs[6] = '{8'h80, 8'h80, 8'h01, 1'b1,  7, 2, 1'b0, -1};
        vecs[7] = '{8'hFF, 8'hFF, 8'hFF, 1'b0, -1, 0, 1'b1, -1};

        // Reset held for 10 ns, outputs checked while in reset and for a few idle cycles after.
        rst  = 1'b0;
        d    = 8'hAB;
        load = 1'b0;
        en   = 1'b0;
        #3 check_quiet("in_reset", 1'b1);
        #7 rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_quiet($sformatf("idle%0d", c), 1'b1);
        end

        // en high in IDLE without load must not start anything.
        en = 1'b1;
        @(negedge clk);
        check_quiet("en_only", 1'b1);

        for (int k = 0; k < 8; k++) begin
            run_frame(vecs[k], k);
        end

        // Back-to-back: load held high across DONE is only taken once IDLE returns.
        d    = 8'h5A;
        load = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_bit($sformatf("b2b bit%0d", i), vecs[4].exp_msb[7-i], vecs[4].exp_lsb[7-i]);
            @(negedge clk);
        end
`ifdef PARITY_EN
        @(negedge clk);
`endif
        check("b2b done_m", done_m, 1'b1);
        @(negedge clk);
        check("b2b ready_m", ready_m, 1'b1);
        @(negedge clk);
        load = 1'b0;
        check_bit("b2b reload bit0", 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
